reorder_buffer: RTL
===================

Name: reorder_buffer

Overview:
Circular in-order retirement queue of the Tomasulo RV32I core. Decoder allocates one entry per issued instruction; ALU and LSB write results back over the CDB; the head entry retires when ready. Register results go to the register file commit port, stores are released to the LSB, and mispredicted branches raise a rollback that flushes the machine.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
ROB_POS_WID, 4, log2(ROB_SIZE); entry index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
rdy  in  1  global enable; when 0, all state frozen
full  out  1  no free entry
issue  in  1  decoder allocates entry at tail
issue_type  in  2  00=REG, 01=STORE, 10=BRANCH
issue_rd  in  5  destination register
issue_pc  in  32  instruction PC
issue_pred_jump  in  1  predictor said taken (BRANCH only)
issue_ready  in  1  result already known at issue (e.g. LUI)
issue_val  in  32  value when issue_ready=1
tail_pos  out  ROB_POS_WID  index the next issue receives
alu_valid  in  1  ALU CDB broadcast
alu_rob_pos  in  ROB_POS_WID  target entry
alu_val  in  32  result / link value
alu_jump  in  1  branch actually taken
alu_target  in  32  actual jump target
lsb_valid  in  1  LSB CDB broadcast (load data or store address ready)
lsb_rob_pos  in  ROB_POS_WID  target entry
lsb_val  in  32  load data
q1_pos, q2_pos  in  ROB_POS_WID  decoder operand queries
q1_ready, q2_ready  out  1  queried entry holds a value
q1_val, q2_val  out  32  queried value
reg_commit  out  1  register file write
reg_commit_rd  out  5  destination
reg_commit_val  out  32  value
reg_commit_pos  out  ROB_POS_WID  retiring entry index
store_commit  out  1  release store at lsb head
store_commit_pos  out  ROB_POS_WID  retiring store entry
rollback  out  1  mispredict flush pulse
rollback_pc  out  32  fetch restart PC

Behaviour:
- Reset: head=tail=count=0, all entry ready bits 0, every output 0 (full=0, tail_pos=0).
- full = (count == ROB_SIZE), combinational. An issue while full is ignored, including in the same cycle as a commit.
- Issue (rdy, !full, !rollback): entry[tail] <= {type, rd, pc, pred_jump, ready=issue_ready, val=issue_val}; tail <= tail+1 mod ROB_SIZE.
- Write-back: on alu_valid, entry[alu_rob_pos] gets ready=1, val, jump, target; on lsb_valid, entry[lsb_rob_pos] gets ready=1, val. Both may occur in one cycle to distinct entries. A write to an empty/stale entry is undefined for the producer and need not be handled.
- Query (combinational): q_ready/q_val = entry state, overridden by a same-cycle alu/lsb broadcast to that position (ALU has priority if both match).
- Commit: at most one per cycle, evaluated on registered state. If count>0 and entry[head].ready, retire head: head+1, and commit outputs are registered, so they are valid the next cycle for exactly one cycle. A write-back to head therefore retires at the earliest one cycle later.
  - REG: reg_commit=1, unless rd==0, in which case reg_commit stays 0 and the entry still retires.
  - STORE: store_commit=1, store_commit_pos=head.
  - BRANCH: writes link like REG when rd!=0. If jump != pred_jump, rollback=1 with rollback_pc = jump ? target : pc+4.
- Simultaneous issue and commit: count unchanged.
- Rollback: in the cycle the mispredict is retired, head=tail=count=0 and all ready bits are cleared. The registered rollback pulse appears the next cycle. During the rollback-high cycle, issue and write-backs are ignored.
- rdy=0: no state change; registered outputs hold their values.
- rst has priority over everything, mid-operation included.

Decomposition:
- Shared macros.v: ROB_SIZE, ROB_POS_WID, ROB_ID_WID (= ROB_POS_WID+1), DATA_WID, REG_POS_WID, type encodings ROB_TYPE_REG/STORE/BRANCH.
- Entry storage is parallel register arrays inside the module; no sub-module.

Test Plan:
- Reset, then issue REG rd=5, then alu_valid pos 0 val=0x1234 -> one cycle later reg_commit=1, rd=5, val=0x1234, pos=0; count returns to 0.
- Issue 16 entries -> full=1; 17th issue ignored, tail_pos stays 0; one commit frees a slot, then issue succeeds at pos 0 (wrap).
- Issue REG rd=0 with issue_ready=1 val=7 -> entry retires, reg_commit stays 0.
- BRANCH pc=0x100 pred_jump=0, alu_jump=1 target=0x200, younger entries queued -> rollback=1, rollback_pc=0x200; next cycle count=0, tail_pos=0, queued entries never commit.
- Out-of-order write-back (pos 1 before pos 0) -> commits strictly in order 0 then 1. Query q1_pos=1 in the same cycle as alu_valid pos 1 val=9 -> q1_ready=1, q1_val=9.
- STORE entry with lsb_valid -> store_commit=1, store_commit_pos correct. rdy=0 for 3 cycles mid-stream -> no commit or pointer change.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared constants and type encodings for the reorder buffer.
// Pure declarations: no logic, no timing.
// Imported by the reorder buffer and anything that talks to it.
package reorder_buffer_pkg;

    localparam int ROB_SIZE    = 16;
    localparam int ROB_POS_WID = 4;
    localparam int ROB_ID_WID  = ROB_POS_WID + 1;
    localparam int DATA_WID    = 32;
    localparam int REG_POS_WID = 5;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'b00,
        ROB_TYPE_STORE  = 2'b01,
        ROB_TYPE_BRANCH = 2'b10
    } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, collects CDB results, retires head.
// Latency: a head that became ready retires on the next edge; commit outputs are
// registered (one cycle after retire). Backpressure: full blocks issue; rdy=0 freezes all.
//
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   issue*      : decoder allocation at tail; tail_pos/full report allocation state
//   alu_*/lsb_* : CDB write-back to an entry index
//   q1_*/q2_*   : combinational operand lookup with same-cycle CDB bypass
//   reg_commit* : register file write for retired REG/BRANCH entries (rd != 0)
//   store_commit*: release of a retired store to the load/store buffer
//   rollback*   : mispredict flush pulse and restart PC
module reorder_buffer #(
    parameter int ROB_SIZE    = reorder_buffer_pkg::ROB_SIZE,
    parameter int ROB_POS_WID = reorder_buffer_pkg::ROB_POS_WID
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    output logic                   full,
    input  logic                   issue,
    input  logic [1:0]             issue_type,
    input  logic [4:0]             issue_rd,
    input  logic [31:0]            issue_pc,
    input  logic                   issue_pred_jump,
    input  logic                   issue_ready,
    input  logic [31:0]            issue_val,
    output logic [ROB_POS_WID-1:0] tail_pos,
    input  logic                   alu_valid,
    input  logic [ROB_POS_WID-1:0] alu_rob_pos,
    input  logic [31:0]            alu_val,
    input  logic                   alu_jump,
    input  logic [31:0]            alu_target,
    input  logic                   lsb_valid,
    input  logic [ROB_POS_WID-1:0] lsb_rob_pos,
    input  logic [31:0]            lsb_val,
    input  logic [ROB_POS_WID-1:0] q1_pos,
    input  logic [ROB_POS_WID-1:0] q2_pos,
    output logic                   q1_ready,
    output logic                   q2_ready,
    output logic [31:0]            q1_val,
    output logic [31:0]            q2_val,
    output logic                   reg_commit,
    output logic [4:0]             reg_commit_rd,
    output logic [31:0]            reg_commit_val,
    output logic [ROB_POS_WID-1:0] reg_commit_pos,
    output logic                   store_commit,
    output logic [ROB_POS_WID-1:0] store_commit_pos,
    output logic                   rollback,
    output logic [31:0]            rollback_pc
);
    import reorder_buffer_pkg::*;

    localparam logic [ROB_POS_WID:0] FULL_CNT = (ROB_POS_WID+1)'(ROB_SIZE);

    // Entry storage: parallel arrays indexed by ROB position.
    rob_type_e              typ_q  [ROB_SIZE];
    logic [REG_POS_WID-1:0] rd_q   [ROB_SIZE];
    logic [DATA_WID-1:0]    pc_q   [ROB_SIZE];
    logic [DATA_WID-1:0]    val_q  [ROB_SIZE];
    logic [DATA_WID-1:0]    tgt_q  [ROB_SIZE];
    logic                   pred_q [ROB_SIZE];
    logic                   jump_q [ROB_SIZE];
    logic [ROB_SIZE-1:0]    ready_q;

    logic [ROB_POS_WID-1:0] head;
    logic [ROB_POS_WID-1:0] tail;
    logic [ROB_POS_WID:0]   count;

    logic                   issue_en;
    logic                   wb_alu_en;
    logic                   wb_lsb_en;
    logic                   commit_en;
    logic                   commit_store;
    logic                   commit_reg;
    logic                   mispredict;
    logic [DATA_WID-1:0]    restart_pc;

    assign full     = (count == FULL_CNT);
    assign tail_pos = tail;

    // While the rollback pulse is high the pipeline is being flushed, so
    // anything arriving from the decoder or CDB belongs to squashed work.
    assign issue_en  = rdy && issue && !full && !rollback;
    assign wb_alu_en = rdy && alu_valid && !rollback;
    assign wb_lsb_en = rdy && lsb_valid && !rollback;

    // Retirement looks only at registered state, so a same-cycle write-back
    // to the head cannot retire it until the following edge.
    assign commit_en    = rdy && (count != '0) && ready_q[head];
    assign commit_store = (typ_q[head] == ROB_TYPE_STORE);
    assign commit_reg   = commit_en && !commit_store && (rd_q[head] != '0);
    assign mispredict   = commit_en && (typ_q[head] == ROB_TYPE_BRANCH) &&
                          (jump_q[head] != pred_q[head]);
    assign restart_pc   = jump_q[head] ? tgt_q[head] : (pc_q[head] + 32'd4);

    // Operand lookup: CDB bypass beats stored state, ALU beats LSB.
    always_comb begin
        q1_ready = ready_q[q1_pos];
        q1_val   = val_q[q1_pos];
        q2_ready = ready_q[q2_pos];
        q2_val   = val_q[q2_pos];
        if (lsb_valid && (lsb_rob_pos == q1_pos)) begin
            q1_ready = 1'b1;
            q1_val   = lsb_val;
        end
        if (alu_valid && (alu_rob_pos == q1_pos)) begin
            q1_ready = 1'b1;
            q1_val   = alu_val;
        end
        if (lsb_valid && (lsb_rob_pos == q2_pos)) begin
            q2_ready = 1'b1;
            q2_val   = lsb_val;
        end
        if (alu_valid && (alu_rob_pos == q2_pos)) begin
            q2_ready = 1'b1;
            q2_val   = alu_val;
        end
    end

    // Payload storage needs no reset: an entry is only read once its ready
    // bit (which is reset) says it holds valid data.
    always_ff @(posedge clk) begin
        if (issue_en) begin
            typ_q[tail]  <= rob_type_e'(issue_type);
            rd_q[tail]   <= issue_rd;
            pc_q[tail]   <= issue_pc;
            pred_q[tail] <= issue_pred_jump;
            val_q[tail]  <= issue_val;
            jump_q[tail] <= 1'b0;
        end
        if (wb_lsb_en) begin
            val_q[lsb_rob_pos] <= lsb_val;
        end
        if (wb_alu_en) begin
            val_q[alu_rob_pos]  <= alu_val;
            jump_q[alu_rob_pos] <= alu_jump;
            tgt_q[alu_rob_pos]  <= alu_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            ready_q          <= '0;
            reg_commit       <= 1'b0;
            reg_commit_rd    <= '0;
            reg_commit_val   <= '0;
            reg_commit_pos   <= '0;
            store_commit     <= 1'b0;
            store_commit_pos <= '0;
            rollback         <= 1'b0;
            rollback_pc      <= '0;
        end else if (rdy) begin
            if (issue_en) begin
                tail          <= tail + 1'b1;
                ready_q[tail] <= issue_ready;
            end
            if (wb_alu_en) ready_q[alu_rob_pos] <= 1'b1;
            if (wb_lsb_en) ready_q[lsb_rob_pos] <= 1'b1;
            if (commit_en) head <= head + 1'b1;

            case ({issue_en, commit_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            reg_commit <= commit_reg;
            if (commit_reg) begin
                reg_commit_rd  <= rd_q[head];
                reg_commit_val <= val_q[head];
                reg_commit_pos <= head;
            end

            store_commit <= commit_en && commit_store;
            if (commit_en && commit_store) store_commit_pos <= head;

            rollback <= mispredict;
            if (mispredict) rollback_pc <= restart_pc;

            // A retiring mispredict discards every younger entry, including
            // anything issued or written back in this same cycle.
            if (mispredict) begin
                head    <= '0;
                tail    <= '0;
                count   <= '0;
                ready_q <= '0;
            end
        end
    end

endmodule
